// File: rtl/systolic_3by3_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_3by3_ctrl_pkg
//  Description : Shared types and schedule constants for the 3x3
//                weight-stationary systolic array sequencer. The array
//                wrapper and the bench import the default capture schedule
//                from here, so all three agree on when each result appears.
//  Revision    : 1.0 - initial release
// ============================================================================
package systolic_3by3_ctrl_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CLEAR = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int DIM          = 3;            // array edge length
    localparam int NUM_OPERANDS = 18;           // B weights followed by A rows
    localparam int NUM_W        = 9;            // number of B weights
    localparam int NUM_A        = 9;            // number of A elements
    localparam int IDX_W        = 5;            // holds 0..NUM_OPERANDS-1

    // Default operand width and capture schedule of the array
    localparam int DEF_DW      = 8;
    localparam int DEF_CAP_C22 = 5;
    localparam int DEF_CAP_C21 = 6;
    localparam int DEF_CAP_C12 = 9;
    localparam int DEF_CAP_C11 = 10;

    // Capture cycles must be distinct and strictly increasing, C11 last.
    function automatic bit caps_legal(input int c22, input int c21,
                                      input int c12, input int c11);
        return (c22 >= 0) && (c22 < c21) && (c21 < c12) && (c12 < c11);
    endfunction

endpackage : systolic_3by3_ctrl_pkg
`default_nettype wire

// File: rtl/systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_skew_feeder
//  Description : Holds the A operand matrix and drives the three array row
//                inputs with a one-cycle-per-row skew. Lane k (0-based)
//                carries column k of A, row r appearing at run cycle r+k.
//                Outputs are registered from the next-cycle run index, so
//                the value presented during run cycle t is the one for t.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk        in   clock
//    rst        in   asynchronous reset, active low
//    a_we_i     in   write strobe for the A buffer
//    a_idx_i    in   A element index, row-major 0..8
//    a_data_i   in   A element value
//    drive_i    in   next cycle is a RUN cycle (otherwise lanes go to 0)
//    t_i        in   run cycle index of the next cycle
//    left1_o    out  row input 1 of the array (A column 1)
//    left2_o    out  row input 2 of the array (A column 2)
//    left3_o    out  row input 3 of the array (A column 3)
// ============================================================================
module systolic_skew_feeder
    import systolic_3by3_ctrl_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_we_i,
    input  logic [3:0]    a_idx_i,
    input  logic [DW-1:0] a_data_i,
    input  logic          drive_i,
    input  logic [TW-1:0] t_i,
    output logic [DW-1:0] left1_o,
    output logic [DW-1:0] left2_o,
    output logic [DW-1:0] left3_o
);

    logic [DW-1:0] a_q    [NUM_A];
    logic [DW-1:0] left_d [DIM];
    logic [DW-1:0] left_q [DIM];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_A; i++) a_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_A; i++) begin
                if (a_we_i && (a_idx_i == 4'(i))) a_q[i] <= a_data_i;
            end
        end
    end

    // Lane k shows A[r][k] when the next run index equals r+k; any index
    // outside the three-row window (and any non-RUN cycle) yields zero.
    always_comb begin
        for (int k = 0; k < DIM; k++) begin
            left_d[k] = '0;
            for (int r = 0; r < DIM; r++) begin
                if (drive_i && (t_i == TW'(r + k))) left_d[k] = a_q[r*DIM + k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DIM; k++) left_q[k] <= '0;
        end else begin
            for (int k = 0; k < DIM; k++) left_q[k] <= left_d[k];
        end
    end

    assign left1_o = left_q[0];
    assign left2_o = left_q[1];
    assign left3_o = left_q[2];

endmodule : systolic_skew_feeder
`default_nettype wire

// File: rtl/systolic_3by3_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_3by3_ctrl
//  Description : Sequencer for the 3x3 weight-stationary systolic array.
//                Collects an 18-byte operand stream (B weights then A rows),
//                holds B on the weight ports, clears the array for one cycle,
//                streams A with row skew, captures the array column sum at
//                fixed run cycles into C11..C22 and pulses done.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk              in   clock
//    rst              in   asynchronous reset, active low
//    in_valid         in   operand byte valid
//    in_data          in   operand byte (B11..B33 then A11..A33, row-major)
//    in_ready         out  byte accepted this cycle when in_valid is high
//    abort            in   synchronous abort back to IDLE
//    busy             out  high during CLEAR and RUN
//    done             out  one-cycle pulse when C11..C22 are valid
//    arr_rst_n        out  array reset, low for the single CLEAR cycle
//    B11..B33         out  weight operands held for the array
//    left1..left3     out  skewed A row inputs to the array
//    arr_out          in   array column-sum output
//    C11,C12,C21,C22  out  captured results
// ============================================================================
module systolic_3by3_ctrl
    import systolic_3by3_ctrl_pkg::*;
#(
    parameter int DW      = DEF_DW,
    parameter int CAP_C22 = DEF_CAP_C22,
    parameter int CAP_C21 = DEF_CAP_C21,
    parameter int CAP_C12 = DEF_CAP_C12,
    parameter int CAP_C11 = DEF_CAP_C11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          arr_rst_n,
    output logic [DW-1:0] B11,
    output logic [DW-1:0] B12,
    output logic [DW-1:0] B13,
    output logic [DW-1:0] B21,
    output logic [DW-1:0] B22,
    output logic [DW-1:0] B23,
    output logic [DW-1:0] B31,
    output logic [DW-1:0] B32,
    output logic [DW-1:0] B33,
    output logic [DW-1:0] left1,
    output logic [DW-1:0] left2,
    output logic [DW-1:0] left3,
    input  logic [DW-1:0] arr_out,
    output logic [DW-1:0] C11,
    output logic [DW-1:0] C12,
    output logic [DW-1:0] C21,
    output logic [DW-1:0] C22
);

    // Run counter must at least reach 4 so the skew window (0..4) decodes.
    localparam int TW = ($clog2(CAP_C11 + 1) < 3) ? 3 : $clog2(CAP_C11 + 1);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_OPERANDS - 1);
    localparam logic [IDX_W-1:0] FIRST_A   = IDX_W'(NUM_W);
    localparam logic [TW-1:0]    T_C22     = TW'(CAP_C22);
    localparam logic [TW-1:0]    T_C21     = TW'(CAP_C21);
    localparam logic [TW-1:0]    T_C12     = TW'(CAP_C12);
    localparam logic [TW-1:0]    T_C11     = TW'(CAP_C11);

    if (!caps_legal(CAP_C22, CAP_C21, CAP_C12, CAP_C11)) begin : g_bad_caps
        $error("systolic_3by3_ctrl: capture cycles must be distinct and increasing");
    end

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [TW-1:0]        t_q, t_d;
    logic                 in_ready_q;
    logic [DW-1:0]        b_q [NUM_W];
    logic [DW-1:0]        c11_q, c12_q, c21_q, c22_q;
    logic                 accept;
    logic                 a_we;
    logic [3:0]           a_idx;

    // Abort takes priority over a handshake in the same cycle.
    assign accept = in_valid && in_ready_q && !abort;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            t_q     <= t_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        t_d       = t_q;
        busy      = 1'b0;
        done      = 1'b0;
        arr_rst_n = 1'b1;

        case (state_q)
            ST_CLEAR: begin
                busy      = 1'b1;
                arr_rst_n = 1'b0;
            end
            ST_RUN:   busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default:  ;
        endcase

        if (abort) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            t_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        idx_d   = IDX_W'(1);
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        if (idx_q == LAST_IDX) begin
                            idx_d   = '0;
                            state_d = ST_CLEAR;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                ST_CLEAR: begin
                    state_d = ST_RUN;
                    t_d     = '0;
                end
                ST_RUN: begin
                    if (t_q == T_C11) begin
                        state_d = ST_DONE;
                        t_d     = '0;
                    end else begin
                        t_d = t_q + TW'(1);
                    end
                end
                ST_DONE:  state_d = ST_IDLE;
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    t_d     = '0;
                end
            endcase
        end
    end

    // in_ready is registered from the next state so it is low during reset
    // and never depends combinationally on in_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) in_ready_q <= 1'b0;
        else      in_ready_q <= (state_d == ST_IDLE) || (state_d == ST_LOAD);
    end

    assign in_ready = in_ready_q;

    // ------------------------------------------------------------- B buffer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_W; i++) b_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_W; i++) begin
                if (accept && (idx_q == IDX_W'(i))) b_q[i] <= in_data;
            end
        end
    end

    assign B11 = b_q[0];
    assign B12 = b_q[1];
    assign B13 = b_q[2];
    assign B21 = b_q[3];
    assign B22 = b_q[4];
    assign B23 = b_q[5];
    assign B31 = b_q[6];
    assign B32 = b_q[7];
    assign B33 = b_q[8];

    // ------------------------------------------------------- A buffer + skew
    assign a_we  = accept && (idx_q >= FIRST_A);
    assign a_idx = 4'(idx_q - FIRST_A);

    systolic_skew_feeder #(
        .DW (DW),
        .TW (TW)
    ) u_feeder (
        .clk      (clk),
        .rst      (rst),
        .a_we_i   (a_we),
        .a_idx_i  (a_idx),
        .a_data_i (in_data),
        .drive_i  (state_d == ST_RUN),
        .t_i      (t_d),
        .left1_o  (left1),
        .left2_o  (left2),
        .left3_o  (left3)
    );

    // ------------------------------------------------------------- capture
    // The sum is taken verbatim at the clock edge closing the capture cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c11_q <= '0;
            c12_q <= '0;
            c21_q <= '0;
            c22_q <= '0;
        end else if ((state_q == ST_RUN) && !abort) begin
            if (t_q == T_C22) c22_q <= arr_out;
            if (t_q == T_C21) c21_q <= arr_out;
            if (t_q == T_C12) c12_q <= arr_out;
            if (t_q == T_C11) c11_q <= arr_out;
        end
    end

    assign C11 = c11_q;
    assign C12 = c12_q;
    assign C21 = c21_q;
    assign C22 = c22_q;

endmodule : systolic_3by3_ctrl
`default_nettype wire
